down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH SHALL exist: default 4, meaning bit width of the count and load value.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port x SHALL be: input, 1 bit, count enable; 1 = decrement, 0 = hold.
REQ-005 Port load SHALL be: input, 1 bit, load strobe; samples load_val.
REQ-006 Port load_val SHALL be: input, WIDTH bits, start/reload value.
REQ-007 Port auto_reload SHALL be: input, 1 bit, 1 = periodic mode, 0 = one-shot mode; sampled at each terminal count.
REQ-008 Port counter SHALL be: output, WIDTH bits, registered current count.
REQ-009 Port tc SHALL be: output, 1 bit, registered one-cycle terminal-count pulse.
REQ-010 Port busy SHALL be: output, 1 bit, registered; 1 while state is RUN.
REQ-011 There SHALL be one clock (clk); reset SHALL be synchronous and active-high.

Function
REQ-012 State machine SHALL have three states: IDLE, RUN, DONE.
REQ-013 Internal reload register (WIDTH bits) SHALL capture load_val on every accepted load.
REQ-014 Load with load_val != 0 SHALL set counter = load_val and state = RUN next cycle, in any state.
REQ-015 Load with load_val == 0 SHALL set counter = 0 and state = IDLE, with no tc.
REQ-016 Load SHALL take priority over decrement in the same cycle.
REQ-017 In RUN with x = 1 and counter > 1, counter SHALL decrement by 1 per cycle.
REQ-018 In RUN with x = 0, counter and state SHALL hold; tc SHALL be 0.
REQ-019 In RUN with x = 1 and counter == 1, tc SHALL be 1 for exactly the next cycle.
REQ-020 At that event with auto_reload = 1, counter SHALL become the reload value, state SHALL stay RUN, and the period SHALL equal the reload value in enabled cycles.
REQ-021 At that event with auto_reload = 0, counter SHALL become 0 and state SHALL become DONE.
REQ-022 In IDLE and DONE, counter SHALL hold, x SHALL be ignored, and busy SHALL be 0.
REQ-023 Counter SHALL never wrap below 0; no decrement from 0 in any state.
REQ-024 busy SHALL be 1 exactly when state is RUN, registered, with no combinational path from inputs.
REQ-025 Load coinciding with terminal count SHALL suppress tc and apply REQ-014/015.

Reset
REQ-026 reset = 1 SHALL, on the next rising clk, force counter = 0, reload register = 0, tc = 0, busy = 0, state = IDLE.
REQ-027 reset SHALL override load and x in the same cycle, including mid-count.
REQ-028 After reset deasserts, the block SHALL stay IDLE until a load is accepted.

Structure
REQ-029 Package down_counter_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-030 The block SHALL be a single module with no sub-module; the FSM and counter datapath are one always block set.

Verification
REQ-031 Reset held 20 time units, then released -> counter = 0, busy = 0, tc = 0, state IDLE.
REQ-032 Load 5, x = 1, auto_reload = 0 -> counter 5,4,3,2,1,0; tc high once with counter = 0; busy falls; counter then holds 0.
REQ-033 Load 3, auto_reload = 1, x = 1 for 9 cycles -> sequence 3,2,1,3,2,1,3,2,1; tc pulses every 3rd cycle.
REQ-034 Load 9, x = 1 for 2 cycles, x = 0 for 4 cycles, x = 1 -> counter holds at 7 while paused, no tc, busy stays 1.
REQ-035 Load 6, then reset asserted at counter = 4 -> counter = 0, busy = 0 next cycle; a subsequent load 2 counts 2,1,0.
REQ-036 Load 0 -> IDLE, no tc; load 15 (max) while counter = 1 with x = 1 -> counter = 15 with tc = 0.

Source files
------------

// File: rtl/down_counter_pkg.sv
// down_counter_pkg
//   Shared definitions for the down_counter block:
//     state_t        - controller states (IDLE, RUN, DONE)
//     DEFAULT_WIDTH  - default bit width of the count and load value
package down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// down_counter
//   Loadable down counter with a terminal-count pulse and a one-shot or
//   periodic (auto-reload) mode.
//
// Ports
//   clk          in   single clock; all state changes on its rising edge
//   reset        in   synchronous active-high reset
//   x            in   count enable (1 = decrement, 0 = hold)
//   load         in   load strobe; samples load_val
//   load_val     in   [WIDTH] start / reload value
//   auto_reload  in   1 = periodic, 0 = one-shot; sampled at terminal count
//   counter      out  [WIDTH] registered current count
//   tc           out  registered one-cycle terminal-count pulse
//   busy         out  registered; 1 while the controller is in RUN
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg,   state_next;
  logic [WIDTH-1:0] counter_reg, counter_next;
  logic [WIDTH-1:0] reload_reg,  reload_next;
  logic             tc_reg,      tc_next;
  logic             busy_reg,    busy_next;

  // State and datapath registers. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      reload_reg  <= '0;
      tc_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      reload_reg  <= reload_next;
      tc_reg      <= tc_next;
      busy_reg    <= busy_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    reload_next  = reload_reg;
    tc_next      = 1'b0;

    if (load) begin
      // A load beats decrement and swallows a coincident terminal count.
      reload_next  = load_val;
      counter_next = load_val;
      state_next   = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_reg)
        RUN: begin
          if (x) begin
            if (counter_reg > ONE) begin
              counter_next = counter_reg - ONE;
            end else if (counter_reg == ONE) begin
              tc_next = 1'b1;
              if (auto_reload) begin
                // Reload value is never 0 here: a zero load lands in IDLE.
                counter_next = reload_reg;
                state_next   = RUN;
              end else begin
                counter_next = '0;
                state_next   = DONE;
              end
            end
            // counter_reg == 0 cannot occur in RUN; hold rather than wrap.
          end
        end
        IDLE, DONE: begin
          // Hold; x is ignored until the next load.
        end
        default: begin
          state_next   = IDLE;
          counter_next = '0;
        end
      endcase
    end

    // busy is a flop fed from the next state so it tracks RUN exactly.
    busy_next = (state_next == RUN);
  end

  assign counter = counter_reg;
  assign tc      = tc_reg;
  assign busy    = busy_reg;

endmodule : down_counter

// File: tb/tb_down_counter.sv
module tb_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         x;
  logic         load;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic [W-1:0] counter;
  logic         tc;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .counter     (counter),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         ar;
    logic [W-1:0] ec;
    logic         et;
    logic         eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ld, input logic [W-1:0] lv,
                     input logic en, input logic ar,
                     input logic [W-1:0] ec, input logic et, input logic eb);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
    v.ec = ec; v.et = et; v.eb = eb;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic ld, input logic [W-1:0] lv,
                      input logic en, input logic ar);
    @(negedge clk);
    reset = rst; load = ld; load_val = lv; x = en; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] ec,
                       input logic et, input logic eb);
    checks++;
    if (counter !== ec || tc !== et || busy !== eb) begin
      failures++;
      $display("FAIL %s: got counter=%0d tc=%0b busy=%0b, expected counter=%0d tc=%0b busy=%0b",
               name, counter, tc, busy, ec, et, eb);
    end else begin
      $display("ok   %s: counter=%0d tc=%0b busy=%0b", name, counter, tc, busy);
    end
  endtask

  initial begin
    logic [W-1:0] m;
    logic         m_tc;
    int           n;
    bit           seen;

    reset = 1'b1; load = 1'b0; load_val = '0; x = 1'b0; auto_reload = 1'b0;

    // Reset held for 20 time units (two rising edges).
    #20;
    #1;
    check("reset", 4'd0, 1'b0, 1'b0);

    //   rst ld lv  x  ar   counter tc busy
    // Stays idle after reset with x asserted
    add(0, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    add(0, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    // One-shot from 5
    add(0, 1, 4'd5, 1, 0,  4'd5, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd4, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd3, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd0, 1, 0);
    add(0, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    add(0, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    // Periodic from 3
    add(0, 1, 4'd3, 1, 1,  4'd3, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd3, 1, 1);
    add(0, 0, 4'd0, 1, 1,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd3, 1, 1);
    add(0, 0, 4'd0, 1, 1,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd3, 1, 1);
    // Switch to one-shot mid-period: sampled only at terminal count
    add(0, 0, 4'd0, 1, 0,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd0, 1, 0);
    // Pause at 7
    add(0, 1, 4'd9, 1, 0,  4'd9, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd8, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd7, 0, 1);
    add(0, 0, 4'd0, 0, 0,  4'd7, 0, 1);
    add(0, 0, 4'd0, 0, 0,  4'd7, 0, 1);
    add(0, 0, 4'd0, 0, 0,  4'd7, 0, 1);
    add(0, 0, 4'd0, 0, 0,  4'd7, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd6, 0, 1);
    // Reset mid-count, then load 2
    add(0, 1, 4'd6, 1, 0,  4'd6, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd5, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd4, 0, 1);
    add(1, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    add(0, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    add(0, 1, 4'd2, 1, 0,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd0, 1, 0);
    // Reset overrides a simultaneous load
    add(1, 1, 4'd7, 1, 0,  4'd0, 0, 0);
    // Load 0 -> IDLE, no tc
    add(0, 1, 4'd0, 1, 0,  4'd0, 0, 0);
    add(0, 0, 4'd0, 1, 0,  4'd0, 0, 0);
    // Load 15 at counter == 1 with x = 1 suppresses tc
    add(0, 1, 4'd3, 1, 0,  4'd3, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd1, 0, 1);
    add(0, 1, 4'd15, 1, 0, 4'd15, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd14, 0, 1);
    // Load 0 during RUN drops to IDLE
    add(0, 1, 4'd0, 1, 0,  4'd0, 0, 0);
    // Load 0 coinciding with terminal count
    add(0, 1, 4'd2, 1, 1,  4'd2, 0, 1);
    add(0, 0, 4'd0, 1, 1,  4'd1, 0, 1);
    add(0, 1, 4'd0, 1, 1,  4'd0, 0, 0);
    // Load while DONE restarts
    add(0, 1, 4'd1, 1, 0,  4'd1, 0, 1);
    add(0, 0, 4'd0, 1, 0,  4'd0, 1, 0);
    add(0, 1, 4'd4, 0, 0,  4'd4, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
      check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].et, vecs[i].eb);
    end

    // Periodic run from 4 against a small reference model, with x gaps.
    step(0, 1, 4'd4, 0, 1);
    check("per_load", 4'd4, 1'b0, 1'b1);
    m = 4'd4;
    for (int i = 0; i < 14; i++) begin
      logic en;
      en = (i % 5 != 4);
      m_tc = 1'b0;
      if (en) begin
        if (m == 4'd1) begin
          m = 4'd4;
          m_tc = 1'b1;
        end else begin
          m = m - 4'd1;
        end
      end
      step(0, 0, 4'd0, en, 1);
      check($sformatf("per%0d", i), m, m_tc, 1'b1);
    end

    // One-shot from 5: tc must arrive exactly 5 enabled cycles after load.
    step(0, 1, 4'd5, 1, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step(0, 0, 4'd0, 1, 0);
      n++;
      if (tc === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 5) begin
      failures++;
      $display("FAIL tc_latency: got seen=%0b cycles=%0d, expected seen=1 cycles=5", seen, n);
    end else begin
      $display("ok   tc_latency: cycles=%0d", n);
    end
    check("tc_latency_state", 4'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_down_counter
